vid_in_axis_bridge: RTL and testbench
=====================================

// Module: vid_in_axis_bridge
// PURPOSE
//  Video-in to AXI4-Stream bridge: the capture-side counterpart of the VDMA video-out path.
//  Samples parallel video (hsync/vsync/VDE/data) in the PixelClk domain and emits AXI4-Stream
//  video (tuser = start of frame, tlast = end of line) for the VDMA S2MM write channel.
//  Small FIFO absorbs tready backpressure; frame and line faults force a resync to the next vsync.
// PARAMETERS
//  DATA_WIDTH    24   pixel width, RGB888
//  IMAGE_WIDTH   640  active pixels per line
//  IMAGE_HEIGHT  480  active lines per frame
//  FIFO_DEPTH    16   pixel FIFO entries; power of 2, >= 4
// PORTS
//  PixelClk       in   1           pixel clock; only clock
//  vid_rstn       in   1           synchronous active-low reset
//  vid_hsync      in   1           horizontal sync, active-high
//  vid_vsync      in   1           vertical sync, active-high
//  vid_VDE        in   1           active video enable
//  vid_data       in   DATA_WIDTH  pixel data, valid when vid_VDE=1
//  m_axis_tdata   out  DATA_WIDTH  stream pixel
//  m_axis_tvalid  out  1           stream valid
//  m_axis_tready  in   1           stream ready
//  m_axis_tuser   out  1           1 on first pixel of frame
//  m_axis_tlast   out  1           1 on last pixel of line
//  err_overflow   out  1           sticky: pixel dropped, FIFO full
//  err_line       out  1           sticky: VDE run length != IMAGE_WIDTH
//  frame_cnt      out  16          completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (vid_rstn=0 at PixelClk edge): all outputs 0, FIFO empty, state WAIT_VSYNC, counters 0.
//  - Inputs registered once (stage S1); edge detect on S1 vsync and VDE.
//  - FSM: WAIT_VSYNC -(vsync rising)-> WAIT_SOF -(first S1 VDE=1)-> ACTIVE
//    -(last pixel of line IMAGE_HEIGHT-1 pushed)-> WAIT_VSYNC, frame_cnt++.
//    Pixels outside ACTIVE (incl. first SOF pixel from WAIT_SOF, which is pushed) are handled:
//    WAIT_VSYNC drops all pixels; WAIT_SOF pushes the first VDE pixel with tuser=1 and enters ACTIVE.
//  - col counter 0..IMAGE_WIDTH-1 per VDE pixel; tlast=1 when col==IMAGE_WIDTH-1, then col=0, row++.
//  - Line fault: VDE falls with col!=0, or VDE stays high past col wrap -> err_line=1, discard rest
//    of frame, WAIT_VSYNC. Pixels already in FIFO are still drained.
//  - vsync rising while ACTIVE (short frame): err_line=1, go to WAIT_SOF directly, no frame_cnt++.
//  - FIFO: first-word-fall-through; entry = {tuser,tlast,data}. Push accepted when count<FIFO_DEPTH
//    or a pop occurs same cycle. Pop when tvalid & tready. tvalid = !empty.
//  - Overflow: push refused -> pixel dropped, err_overflow=1, frame aborted, WAIT_VSYNC.
//  - Latency: pixel with VDE=1 at edge N presents on m_axis at edge N+2 when FIFO empty.
//  - tdata/tuser/tlast stable while tvalid=1 and tready=0 (AXI4-Stream rule).
//  - Sticky errors clear only on reset. Reset mid-frame: FIFO flushed, tvalid=0 next cycle.
// CONFIGURATION
//  VID_IN_TPG_EN defined: S1 data replaced by internal colour bars (8 bars, bar = col*8/IMAGE_WIDTH,
//    bar0 0xFFFFFF, bar1 0xFFFF00, bar2 0x00FFFF, bar3 0x00FF00, bar4 0xFF00FF, bar5 0xFF0000,
//    bar6 0x0000FF, bar7 0x000000); timing from vid_* inputs unchanged; vid_data ignored.
//  VID_IN_TPG_EN undefined: vid_data passed through; no TPG logic synthesised.
// TESTING (bench: IMAGE_WIDTH=8, IMAGE_HEIGHT=4, FIFO_DEPTH=16)
//  1 tready=1, vsync pulse then 4 lines x 8 pixels data=row*16+col -> 32 beats, tuser only on beat 0
//    (data 0x00), tlast on beats 7,15,23,31, frame_cnt=1, no errors.
//  2 Pixels before first vsync after reset -> none emitted; next full frame emitted intact.
//  3 tready=0 whole frame -> 16 beats held in FIFO, err_overflow=1 at 17th pixel, frame_cnt=0;
//    then tready=1 -> exactly 16 beats drained, next frame (after vsync) clean.
//  4 Line 1 with VDE high for 6 pixels only -> err_line=1, beats 0..13 emitted, rest dropped,
//    following frame 32 beats clean, frame_cnt increments.
//  5 tready toggles 1/0 each cycle during frame -> 32 beats, order and flags as scenario 1,
//    tdata stable across stall cycles.
//  6 vid_rstn=0 for 1 cycle mid-line 2 -> tvalid=0, errors 0, frame_cnt=0 next edge; resumes at next vsync.
//  7 VID_IN_TPG_EN defined, scenario 1 timing -> beats per line 0xFFFFFF,0xFFFF00,...,0x000000.

Source files
------------

// File: rtl/vid_in_axis_bridge.sv
// rtl/vid_in_axis_bridge.sv - parallel video capture to AXI4-Stream bridge
//
// Samples hsync/vsync/VDE/data on PixelClk, frames the pixels into an
// AXI4-Stream (tuser = start of frame, tlast = end of line) through a small
// first-word-fall-through FIFO. Line/frame faults and overflow abort the
// frame and resynchronise on the next vsync.
//
// Optional build macro: VID_IN_TPG_EN replaces pixel data with 8 colour bars.
//
// Ports:
//   PixelClk                 pixel clock (only clock)
//   vid_rstn                 synchronous active-low reset
//   vid_hsync/vid_vsync      sync inputs, active-high (hsync not needed for framing)
//   vid_VDE, vid_data        active video enable and pixel data
//   m_axis_t*                AXI4-Stream master towards the S2MM channel
//   err_overflow, err_line   sticky error flags, cleared by reset only
//   frame_cnt                completed frames, wraps
module vid_in_axis_bridge #(
    parameter int DATA_WIDTH   = 24,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                  PixelClk,
    input  logic                  vid_rstn,
    input  logic                  vid_hsync,
    input  logic                  vid_vsync,
    input  logic                  vid_VDE,
    input  logic [DATA_WIDTH-1:0] vid_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  err_overflow,
    output logic                  err_line,
    output logic [15:0]           frame_cnt
);

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + 2;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        WAIT_SOF   = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [15:0]      frame_cnt_nxt;
    logic             err_line_nxt, err_overflow_nxt;

    // ---------------- input stage S1 + edge detect ----------------
    logic                  s1_vsync, s1_vsync_d, s1_vde, s1_vde_d;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  vsync_rise, vde_fall;

    // Framing relies on VDE only; hsync is accepted for interface completeness.
    logic unused_hsync;
    assign unused_hsync = vid_hsync;

    always_ff @(posedge PixelClk) begin
        if (!vid_rstn) begin
            s1_vsync   <= 1'b0;
            s1_vsync_d <= 1'b0;
            s1_vde     <= 1'b0;
            s1_vde_d   <= 1'b0;
        end else begin
            s1_vsync   <= vid_vsync;
            s1_vsync_d <= s1_vsync;
            s1_vde     <= vid_VDE;
            s1_vde_d   <= s1_vde;
        end
    end

    assign vsync_rise = s1_vsync & ~s1_vsync_d;
    assign vde_fall   = s1_vde_d & ~s1_vde;

`ifdef VID_IN_TPG_EN
    // Colour bars indexed by the column of the pixel being pushed.
    logic        unused_data;
    logic [2:0]  tpg_bar;
    logic [23:0] tpg_rgb;

    assign unused_data = ^vid_data;

    always_comb begin
        tpg_bar = 3'((int'(col) * 8) / IMAGE_WIDTH);
        case (tpg_bar)
            3'd0:    tpg_rgb = 24'hFFFFFF;
            3'd1:    tpg_rgb = 24'hFFFF00;
            3'd2:    tpg_rgb = 24'h00FFFF;
            3'd3:    tpg_rgb = 24'h00FF00;
            3'd4:    tpg_rgb = 24'hFF00FF;
            3'd5:    tpg_rgb = 24'hFF0000;
            3'd6:    tpg_rgb = 24'h0000FF;
            default: tpg_rgb = 24'h000000;
        endcase
    end

    assign s1_data = DATA_WIDTH'(tpg_rgb);
`else
    always_ff @(posedge PixelClk) begin
        if (!vid_rstn) begin
            s1_data <= '0;
        end else begin
            s1_data <= vid_data;
        end
    end
`endif

    // ---------------- pixel FIFO (first-word-fall-through) ----------------
    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0] fifo_head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_valid, pop, push_req, push_ok;
    logic             push_tuser, push_tlast;

    assign fifo_valid = (fifo_cnt != '0);
    assign pop        = fifo_valid & m_axis_tready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok    = push_req & ((fifo_cnt != CNT_FULL) | pop);

    always_ff @(posedge PixelClk) begin
        if (!vid_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge PixelClk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {push_tuser, push_tlast, s1_data};
        end
    end

    // Outputs are forced to zero while empty so reset presents all-zero outputs.
    assign fifo_head     = fifo_mem[rd_ptr];
    assign m_axis_tvalid = fifo_valid;
    assign m_axis_tdata  = fifo_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tuser  = fifo_valid & fifo_head[ENT_W-1];
    assign m_axis_tlast  = fifo_valid & fifo_head[ENT_W-2];

    // ---------------- framing FSM ----------------
    always_ff @(posedge PixelClk) begin
        if (!vid_rstn) begin
            state        <= WAIT_VSYNC;
            col          <= '0;
            row          <= '0;
            frame_cnt    <= '0;
            err_line     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            col          <= col_nxt;
            row          <= row_nxt;
            frame_cnt    <= frame_cnt_nxt;
            err_line     <= err_line_nxt;
            err_overflow <= err_overflow_nxt;
        end
    end

    always_comb begin
        logic pix_take;
        state_nxt        = state;
        col_nxt          = col;
        row_nxt          = row;
        frame_cnt_nxt    = frame_cnt;
        err_line_nxt     = err_line;
        err_overflow_nxt = err_overflow;
        push_req         = 1'b0;
        push_tuser       = 1'b0;
        push_tlast       = (col == COL_LAST);
        pix_take         = 1'b0;

        case (state)
            WAIT_VSYNC: begin
                if (vsync_rise) begin
                    state_nxt = WAIT_SOF;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end
            end
            WAIT_SOF: begin
                if (s1_vde) begin
                    push_req   = 1'b1;
                    push_tuser = 1'b1;
                    pix_take   = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    // Short frame: restart immediately on this new frame.
                    err_line_nxt = 1'b1;
                    state_nxt    = WAIT_SOF;
                    col_nxt      = '0;
                    row_nxt      = '0;
                end else if (vde_fall && col != '0) begin
                    err_line_nxt = 1'b1;
                    state_nxt    = WAIT_VSYNC;
                end else if (s1_vde && s1_vde_d && col == '0) begin
                    // VDE run continued past a completed line.
                    err_line_nxt = 1'b1;
                    state_nxt    = WAIT_VSYNC;
                end else if (s1_vde) begin
                    push_req = 1'b1;
                    pix_take = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_VSYNC;
            end
        endcase

        if (pix_take) begin
            if (!push_ok) begin
                err_overflow_nxt = 1'b1;
                state_nxt        = WAIT_VSYNC;
            end else begin
                state_nxt = ACTIVE;
                if (col == COL_LAST) begin
                    col_nxt = '0;
                    if (row == ROW_LAST) begin
                        row_nxt       = '0;
                        state_nxt     = WAIT_VSYNC;
                        frame_cnt_nxt = frame_cnt + 16'd1;
                    end else begin
                        row_nxt = row + 1'b1;
                    end
                end else begin
                    col_nxt = col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vid_in_axis_bridge.sv
// tb/tb_vid_in_axis_bridge.sv - scoreboard bench for vid_in_axis_bridge
`timescale 1ns/1ps
module tb_vid_in_axis_bridge;
    localparam int DW = 24;
    localparam int IW = 8;
    localparam int IH = 4;
    localparam int FD = 16;

    logic          clk = 1'b0;
    logic          rstn, hsync, vsync, vde;
    logic [DW-1:0] vdata;
    logic [DW-1:0] tdata;
    logic          tvalid, tready, tuser, tlast;
    logic          err_ovf, err_line;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    vid_in_axis_bridge #(
        .DATA_WIDTH  (DW),
        .IMAGE_WIDTH (IW),
        .IMAGE_HEIGHT(IH),
        .FIFO_DEPTH  (FD)
    ) dut (
        .PixelClk     (clk),
        .vid_rstn     (rstn),
        .vid_hsync    (hsync),
        .vid_vsync    (vsync),
        .vid_VDE      (vde),
        .vid_data     (vdata),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tuser (tuser),
        .m_axis_tlast (tlast),
        .err_overflow (err_ovf),
        .err_line     (err_line),
        .frame_cnt    (frame_cnt)
    );

    int total = 0;
    int bad   = 0;
    int beats = 0;
    bit mon_en    = 1'b0;
    bit toggle_en = 1'b0;
    logic [DW+1:0] exp_q [$];

    function automatic logic [DW-1:0] exp_data(int r, int c);
`ifdef VID_IN_TPG_EN
        case (c * 8 / IW)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return DW'(r * 16 + c);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        logic [DW+1:0] cur, held, e;
        bit stall;
        stall = 1'b0;
        held  = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            cur = {tuser, tlast, tdata};
            if (stall && tvalid) begin
                chk("hold_stable", 32'(cur), 32'(held));
            end
            if (tvalid && tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'(cur), 32'(e));
                end
            end
            stall = tvalid && !tready;
            held  = cur;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) tready = ~tready;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        @(posedge clk);
        #1 vsync = 1'b1;
        idle(2);
        vsync = 1'b0;
        idle(3);
    endtask

    task automatic pix(input int r, input int c, input bit want);
        @(posedge clk);
        #1;
        vde   = 1'b1;
        vdata = DW'(r * 16 + c);
        if (want) exp_q.push_back({(r == 0 && c == 0), (c == IW - 1), exp_data(r, c)});
    endtask

    task automatic blank();
        @(posedge clk);
        #1;
        vde   = 1'b0;
        vdata = '0;
        hsync = 1'b1;
        idle(2);
        hsync = 1'b0;
        idle(2);
    endtask

    // Full frame; short_row (if >=0) carries only short_len pixels; the first
    // nexp driven pixels are expected at the stream output.
    task automatic drive_frame(input int short_row, input int short_len, input int nexp);
        int idx;
        int n;
        idx = 0;
        vsync_pulse();
        for (int r = 0; r < IH; r++) begin
            n = (r == short_row) ? short_len : IW;
            for (int c = 0; c < n; c++) begin
                pix(r, c, idx < nexp);
                idx++;
            end
            blank();
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tvalid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        idle(4);
        chk(name, 32'(exp_q.size() == 0 && !tvalid), 32'd1);
    endtask

    initial begin
        int b0;
        rstn = 1'b0; hsync = 1'b0; vsync = 1'b0; vde = 1'b0; vdata = '0; tready = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_tuser", 32'(tuser), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_err_ovf", 32'(err_ovf), 32'd0);
        chk("rst_err_line", 32'(err_line), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        mon_en = 1'b1;

        // Pixels before any vsync are dropped.
        for (int c = 0; c < IW; c++) pix(0, c, 1'b0);
        blank();
        idle(6);
        chk("pre_vsync_beats", 32'(beats), 32'd0);
        chk("pre_vsync_frames", 32'(frame_cnt), 32'd0);

        // Clean frame, tready always high.
        b0 = beats;
        drive_frame(-1, 0, 32);
        drain("f1_drained");
        chk("f1_beats", 32'(beats - b0), 32'd32);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_err_ovf", 32'(err_ovf), 32'd0);
        chk("f1_err_line", 32'(err_line), 32'd0);

        // tready toggling every cycle.
        b0 = beats;
        toggle_en = 1'b1;
        drive_frame(-1, 0, 32);
        drain("tog_drained");
        toggle_en = 1'b0;
        @(posedge clk);
        #2 tready = 1'b1;
        chk("tog_beats", 32'(beats - b0), 32'd32);
        chk("tog_frame_cnt", 32'(frame_cnt), 32'd2);

        // Overflow with tready held low.
        b0 = beats;
        tready = 1'b0;
        drive_frame(-1, 0, 16);
        idle(5);
        chk("ovf_err", 32'(err_ovf), 32'd1);
        chk("ovf_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("ovf_no_beats", 32'(beats - b0), 32'd0);
        chk("ovf_tvalid", 32'(tvalid), 32'd1);
        tready = 1'b1;
        drain("ovf_drained");
        chk("ovf_drain_beats", 32'(beats - b0), 32'd16);
        b0 = beats;
        drive_frame(-1, 0, 32);
        drain("post_ovf_drained");
        chk("post_ovf_beats", 32'(beats - b0), 32'd32);
        chk("post_ovf_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("post_ovf_err_line", 32'(err_line), 32'd0);

        // Short line 1: 6 pixels only.
        b0 = beats;
        drive_frame(1, 6, 14);
        drain("short_drained");
        chk("short_err_line", 32'(err_line), 32'd1);
        chk("short_beats", 32'(beats - b0), 32'd14);
        chk("short_frame_cnt", 32'(frame_cnt), 32'd3);
        b0 = beats;
        drive_frame(-1, 0, 32);
        drain("post_short_drained");
        chk("post_short_beats", 32'(beats - b0), 32'd32);
        chk("post_short_frame_cnt", 32'(frame_cnt), 32'd4);

        // Reset pulse mid-line 2: the two pixels already in flight get out, p2 is flushed.
        vsync_pulse();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < IW; c++) pix(r, c, 1'b1);
            blank();
        end
        for (int c = 0; c < 3; c++) pix(2, c, c < 2);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        vde = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
        chk("mid_rst_err_ovf", 32'(err_ovf), 32'd0);
        chk("mid_rst_err_line", 32'(err_line), 32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
        for (int c = 0; c < 4; c++) pix(3, c, 1'b0);
        blank();
        b0 = beats;
        drive_frame(-1, 0, 32);
        drain("resume_drained");
        chk("resume_beats", 32'(beats - b0), 32'd32);
        chk("resume_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
